// File: rtl/fpu_addsub_arbiter.sv
// rtl/fpu_addsub_arbiter.sv - round-robin sharing of one combinational FPU add/sub among NUM_REQ clients
// Optional FPU_ARB_STATS_EN adds saturating completed-op and overflow counters.
module fpu_addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int FPU_LAT = 1,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_op,
  output logic [31:0]           fpu_a,
  output logic [31:0]           fpu_b,
  output logic                  fpu_add_sub,
  input  logic [31:0]           fpu_result,
  input  logic                  fpu_overflow,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_overflow,
  output logic                  busy,
  output logic [15:0]           stat_ops,
  output logic [15:0]           stat_ovf
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state, state_next;
  logic [ID_W-1:0]     rr_ptr, owner, win_idx, ptr_next;
  logic [3:0]          lat_cnt;
  logic                win_found;
  logic [31:0]         sel_a, sel_b;
  logic                sel_op;
  logic [2*NUM_REQ-1:0] rot;
  int                  scan;

  // Rotate the doubled request vector so bit 0 is the client at rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    rot       = {req_valid, req_valid} >> rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && rot[i]) begin
        win_found = 1'b1;
        scan      = int'(rr_ptr) + i;
        if (scan >= NUM_REQ) scan = scan - NUM_REQ;
        win_idx   = ID_W'(scan);
      end
    end
  end

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_op    = 1'b0;
    req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == win_idx) begin
        sel_a  = req_a[32*j +: 32];
        sel_b  = req_b[32*j +: 32];
        sel_op = req_op[j];
        req_ready[j] = (state == IDLE) && win_found;
      end
    end
  end

  assign ptr_next = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found) state_next = EXEC;
      EXEC:    if (lat_cnt == 4'd0) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_a        <= '0;
      fpu_b        <= '0;
      fpu_add_sub  <= 1'b0;
      owner        <= '0;
      rr_ptr       <= '0;
      lat_cnt      <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (win_found) begin
          fpu_a       <= sel_a;
          fpu_b       <= sel_b;
          fpu_add_sub <= sel_op;
          owner       <= win_idx;
          rr_ptr      <= ptr_next;
          lat_cnt     <= 4'(FPU_LAT - 1);
        end
        EXEC: if (lat_cnt != 4'd0) begin
          lat_cnt <= lat_cnt - 4'd1;
        end else begin
          rsp_result   <= fpu_result;
          rsp_overflow <= fpu_overflow;
          rsp_id       <= owner;
          rsp_valid    <= 1'b1;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef FPU_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops <= '0;
      stat_ovf <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (rsp_overflow && stat_ovf != 16'hFFFF) stat_ovf <= stat_ovf + 16'd1;
    end
  end
`else
  assign stat_ops = '0;
  assign stat_ovf = '0;
`endif

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// tb/tb_fpu_addsub_arbiter.sv - directed self-checking bench for fpu_addsub_arbiter
// FPU is a lookup stub keyed on the hand-picked operand vectors; other operands return a^b.
module tb_fpu_addsub_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a, req_b;
  logic [3:0]   req_op;
  logic [31:0]  fpu_a, fpu_b, fpu_result, rsp_result;
  logic         fpu_add_sub, fpu_overflow;
  logic         rsp_valid, rsp_ready, rsp_overflow, busy;
  logic [1:0]   rsp_id;
  logic [15:0]  stat_ops, stat_ovf;

  int errors = 0;
  int checks = 0;
  logic [31:0] fa [4];
  logic [31:0] fb [4];

  always #5 clk = ~clk;

  fpu_addsub_arbiter #(.NUM_REQ(4), .FPU_LAT(1), .ID_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_add_sub(fpu_add_sub),
    .fpu_result(fpu_result), .fpu_overflow(fpu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .busy(busy), .stat_ops(stat_ops), .stat_ovf(stat_ovf)
  );

  always_comb begin
    fpu_result   = fpu_a ^ fpu_b;
    fpu_overflow = 1'b0;
    case ({fpu_a, fpu_b, fpu_add_sub})
      {32'h40400000, 32'h3FC00000, 1'b0}: fpu_result = 32'h40900000;
      {32'hC0400000, 32'h3FC00000, 1'b1}: fpu_result = 32'hC0900000;
      {32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0}: begin
        fpu_result   = 32'h7F800000;
        fpu_overflow = 1'b1;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[i]         = op;
  endtask

  initial begin
    int k, rk, last;
    logic [3:0] exp_g;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_fpu_a", fpu_a, 0);
    chk("rst_fpu_b", fpu_b, 0);
    chk("rst_fpu_op", 32'(fpu_add_sub), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stat_ops", 32'(stat_ops), 0);

    // single add from requester 0
    set_req(0, 32'h40400000, 32'h3FC00000, 1'b0);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    #1 chk("add_grant", 32'(req_ready), 32'h1);
    step(); req_valid = '0; #1;
    chk("add_fpu_a", fpu_a, 32'h40400000);
    chk("add_busy", 32'(busy), 1);
    chk("add_exec_ready", 32'(req_ready), 0);
    chk("add_exec_rsp", 32'(rsp_valid), 0);
    step();
    chk("add_rsp_valid", 32'(rsp_valid), 1);
    chk("add_rsp_id", 32'(rsp_id), 0);
    chk("add_rsp_result", rsp_result, 32'h40900000);
    chk("add_rsp_ovf", 32'(rsp_overflow), 0);
    step();
    chk("add_idle", 32'(busy), 0);
    chk("add_rsp_drop", 32'(rsp_valid), 0);
    chk("add_fpu_hold", fpu_a, 32'h40400000);

    // subtract from requester 2 with response backpressure
    set_req(2, 32'hC0400000, 32'h3FC00000, 1'b1);
    req_valid = 4'b0100; rsp_ready = 1'b0;
    #1 chk("sub_grant", 32'(req_ready), 32'h4);
    step();
    set_req(1, 32'h12345678, 32'h0F0F0F0F, 1'b0);
    req_valid = 4'b0010; #1;
    chk("sub_exec_ready", 32'(req_ready), 0);
    chk("sub_fpu_op", 32'(fpu_add_sub), 1);
    step();
    for (int c = 0; c < 5; c++) begin
      chk("sub_bp_valid", 32'(rsp_valid), 1);
      chk("sub_bp_id", 32'(rsp_id), 2);
      chk("sub_bp_result", rsp_result, 32'hC0900000);
      chk("sub_bp_ready", 32'(req_ready), 0);
      if (c < 4) step();
    end
    step();
    rsp_ready = 1'b1; #1;
    chk("sub_accept_valid", 32'(rsp_valid), 1);
    chk("sub_accept_noready", 32'(req_ready), 0);
    step();
    chk("sub_after_valid", 32'(rsp_valid), 0);
    chk("sub_next_grant", 32'(req_ready), 32'h2);
    step(); req_valid = '0;
    step();
    chk("r1_rsp_id", 32'(rsp_id), 1);
    chk("r1_rsp_result", rsp_result, 32'h12345678 ^ 32'h0F0F0F0F);
    step();

    // overflow from requester 3
    set_req(3, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
    req_valid = 4'b1000;
    #1 chk("ovf_grant", 32'(req_ready), 32'h8);
    step(); req_valid = '0;
    step();
    chk("ovf_result", rsp_result, 32'h7F800000);
    chk("ovf_flag", 32'(rsp_overflow), 1);
    step();
`ifdef FPU_ARB_STATS_EN
    chk("stat_ovf", 32'(stat_ovf), 1);
    chk("stat_ops", 32'(stat_ops), 4);
`else
    chk("stat_ops_tied", 32'(stat_ops), 0);
    chk("stat_ovf_tied", 32'(stat_ovf), 0);
`endif

    // fairness: all four requesting continuously
    for (int i = 0; i < 4; i++) begin
      fa[i] = 32'h01000000 * (i + 1) + 32'h11;
      fb[i] = 32'h00F00000 + i;
      set_req(i, fa[i], fb[i], 1'b0);
    end
    req_valid = 4'b1111;
    k = 0; rk = 0; last = 0;
    for (int t = 0; t < 40 && k < 8; t++) begin
      #1;
      if (req_ready != 4'b0000) begin
        exp_g = 4'(1 << (k % 4));
        chk("fair_grant", 32'(req_ready), 32'(exp_g));
        if (k > 0) chk("fair_interval", 32'(t - last), 3);
        last = t;
        k++;
      end
      if (rsp_valid) begin
        chk("fair_rsp_id", 32'(rsp_id), 32'(rk % 4));
        chk("fair_rsp_result", rsp_result, fa[rk % 4] ^ fb[rk % 4]);
        rk++;
      end
      step();
    end
    req_valid = '0;
    for (int t = 0; t < 10; t++) begin
      #1;
      if (rsp_valid) begin
        chk("fair_rsp_id", 32'(rsp_id), 32'(rk % 4));
        rk++;
      end
      if (!busy) break;
      step();
    end
    chk("fair_grants", 32'(k), 8);
    chk("fair_rsps", 32'(rk), 8);

    // reset in EXEC: op dropped, pointer back to 0
    req_valid = 4'b0010;
    #1 chk("rstop_grant", 32'(req_ready), 32'h2);
    step(); req_valid = '0;
    chk("rstop_busy", 32'(busy), 1);
    rst = 1'b1; #1;
    chk("rstop_async_busy", 32'(busy), 0);
    chk("rstop_async_fpu_a", fpu_a, 0);
    chk("rstop_async_rsp", 32'(rsp_valid), 0);
    chk("rstop_async_stat", 32'(stat_ops), 0);
    step(); rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rstop_no_rsp", 32'(rsp_valid), 0);
    end
    req_valid = 4'b1111;
    #1 chk("rstop_ptr0", 32'(req_ready), 32'h1);
    step(); req_valid = '0;
    step();
    chk("rstop_rsp_id", 32'(rsp_id), 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_addsub_arbiter.md
Name: fpu_addsub_arbiter

Overview:
- Shares one combinational IEEE754_FPU add/sub datapath (a, b, add_sub → result, overflow) among NUM_REQ requesters.
- Round-robin arbitration.
- Registers the operands that drive the FPU and holds them stable for FPU_LAT cycles.
- Captures result and overflow, then returns them on a shared response channel tagged with the requester index.
- Sits between client blocks and the FPU instance.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- FPU_LAT, 1: cycles operands are held before the result is sampled, 1..15.
- ID_W, 2: width of rsp_id; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot grant; handshake when valid&ready
- req_a  in  32*NUM_REQ  operand a, requester i at bits [32i+31:32i]
- req_b  in  32*NUM_REQ  operand b, same packing
- req_op  in  NUM_REQ  0=add, 1=sub
- fpu_a  out  32  registered operand a to FPU
- fpu_b  out  32  registered operand b to FPU
- fpu_add_sub  out  1  registered op to FPU
- fpu_result  in  32  FPU result
- fpu_overflow  in  1  FPU overflow flag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  index of the requester that owns the response
- rsp_result  out  32  captured result
- rsp_overflow  out  1  captured overflow
- busy  out  1  high in any state except IDLE
- stat_ops  out  16  completed operations (optional feature)
- stat_ovf  out  16  completed operations with overflow (optional feature)

Behaviour:
- Reset values: req_ready=0, fpu_a/fpu_b/fpu_add_sub=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_overflow=0, busy=0, state=IDLE, rr_ptr=0, lat_cnt=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid, pick the winner: first set bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready to the winner is combinational and only in IDLE, so the handshake completes in this cycle.
  - At the clock edge: latch the winner's a/b/op into fpu_*, latch the winner index, set rr_ptr = winner+1 mod NUM_REQ, lat_cnt=FPU_LAT-1, go to EXEC.
  - No valid: stay in IDLE; rr_ptr is unchanged.
- EXEC:
  - fpu_* held stable.
  - While lat_cnt != 0, decrement.
  - When lat_cnt == 0, capture fpu_result/fpu_overflow into rsp_result/rsp_overflow, set rsp_id = winner, rsp_valid=1, go to RESP.
- RESP:
  - rsp_* held stable while rsp_valid & !rsp_ready.
  - On rsp_ready: rsp_valid=0, go to IDLE.
  - No new grant in this cycle.
- Latency: grant cycle to rsp_valid = FPU_LAT+1 cycles. Minimum issue interval = FPU_LAT+2 cycles.
- req_ready is all-zero outside IDLE. Requesters hold req_valid/operands until granted; de-asserting before the grant is legal.
- Simultaneous requests: exactly one grant per IDLE cycle. A continuously requesting client waits at most NUM_REQ-1 grants.
- fpu_* retain their last values after completion; they are not cleared.
- Asynchronous rst in any state: the in-flight operation is dropped with no response, and all registers return to reset values immediately.
- Bits of req_valid at index >= NUM_REQ do not exist. rsp_id upper bits beyond the index are zero.

Optional Feature:
- Macro FPU_ARB_STATS_EN.
- Defined:
  - stat_ops increments on each rsp handshake.
  - stat_ovf increments on each rsp handshake with rsp_overflow=1.
  - Both are 16-bit, saturate at 0xFFFF, and reset to 0.
- Undefined: stat_ops and stat_ovf are tied to 0 and no counter flops are generated.

Test Plan:
- Single add: req0 a=0x40400000 (3.0), b=0x3FC00000 (1.5), op=0, FPU_LAT=1 → req_ready[0] same cycle; rsp_valid 2 cycles later with rsp_id=0, result=0x40900000 (4.5), overflow=0.
- Sub with backpressure: req2 a=0xC0400000 (-3.0), b=0x3FC00000, op=1, rsp_ready low 5 cycles → rsp held stable, result=0xC0900000 (-4.5); no grant until the accept cycle plus 1.
- Overflow: a=b=0x7F7FFFFF, op=0 → result=0x7F800000, overflow=1; stat_ovf=1 when FPU_ARB_STATS_EN is defined.
- Fairness: all 4 requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,…; one grant every FPU_LAT+2 cycles.
- Reset mid-op: assert rst in EXEC → rsp_valid never rises for that op; all outputs zero; the next request after release is granted from rr_ptr=0.
- Saturation (FPU_ARB_STATS_EN defined): 65540 completed ops → stat_ops=0xFFFF.
